// File: rtl/secded_codec.sv
// Multi-cycle Hamming SECDED encoder/decoder: one Hamming parity bit per CALC cycle,
// then overall parity (CHECK) and single-error correction / double-error detection (FIX).
module secded_codec #(
   parameter int DATA_W = 11,
   parameter int PAR_W  = 4,
   localparam int CODE_W = DATA_W + PAR_W + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode_in,
   input  logic [DATA_W-1:0] data_in,
   input  logic [CODE_W-1:0] code_in,
   output logic              busy,
   output logic              done,
   output logic [CODE_W-1:0] code_out,
   output logic [DATA_W-1:0] data_out,
   output logic [PAR_W-1:0]  syndrome_out,
   output logic              sec_out,
   output logic              ded_out
);

   localparam int K_W = (PAR_W > 1) ? $clog2(PAR_W) : 1;

   typedef enum logic [2:0] {IDLE, CALC, CHECK, FIX, DONE} state_t;

   state_t            state, state_nxt;
   logic [K_W-1:0]    k;
   logic              mode;
   logic [CODE_W-1:0] word;
   logic [PAR_W-1:0]  syn;
   logic              ov;
   logic              accept;
   logic              cur_par;
   logic [CODE_W-1:0] fix_code;
   logic              fix_sec, fix_ded;

   // Data bits fill the non-power-of-two positions above bit 0 in ascending order.
   function automatic logic [CODE_W-1:0] place(input logic [DATA_W-1:0] d);
      logic [CODE_W-1:0] w;
      int i;
      w = '0;
      i = 0;
      for (int j = 1; j < CODE_W; j++) begin
         if ((j & (j - 1)) != 0) begin
            w[j] = d[i];
            i++;
         end
      end
      return w;
   endfunction

   function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] w);
      logic [DATA_W-1:0] d;
      int i;
      d = '0;
      i = 0;
      for (int j = 1; j < CODE_W; j++) begin
         if ((j & (j - 1)) != 0) begin
            d[i] = w[j];
            i++;
         end
      end
      return d;
   endfunction

   function automatic logic parity_k(input logic [CODE_W-1:0] w, input int kk);
      logic p;
      p = 1'b0;
      for (int j = 1; j < CODE_W; j++) begin
         if (((j >> kk) & 1) != 0) p = p ^ w[j];
      end
      return p;
   endfunction

   assign accept  = start && (state == IDLE || state == DONE);
   assign cur_par = parity_k(word, int'(k));
   assign busy    = (state == CALC) || (state == CHECK) || (state == FIX);
   assign done    = (state == DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CALC;
         CALC:    if (k == K_W'(PAR_W - 1)) state_nxt = CHECK;
         CHECK:   state_nxt = FIX;
         FIX:     state_nxt = DONE;
         DONE:    state_nxt = start ? CALC : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Decode classification; encode passes the word through untouched.
   always_comb begin
      fix_code = word;
      fix_sec  = 1'b0;
      fix_ded  = 1'b0;
      if (mode) begin
         if (syn == '0) begin
            if (ov) begin
               fix_code[0] = ~word[0];
               fix_sec     = 1'b1;
            end
         end else if (!ov || int'(syn) >= CODE_W) begin
            fix_ded = 1'b1;
         end else begin
            for (int j = 1; j < CODE_W; j++) begin
               if (int'(syn) == j) fix_code[j] = ~word[j];
            end
            fix_sec = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         k            <= '0;
         code_out     <= '0;
         data_out     <= '0;
         syndrome_out <= '0;
         sec_out      <= 1'b0;
         ded_out      <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept)
            k <= '0;
         else if (state == CALC)
            k <= k + 1'b1;
         if (state == FIX) begin
            code_out     <= fix_code;
            data_out     <= extract(fix_code);
            syndrome_out <= mode ? syn : '0;
            sec_out      <= fix_sec;
            ded_out      <= fix_ded;
         end
      end
   end

   // Working word, mode and syndrome need no reset: they are always loaded before use.
   always_ff @(posedge clk) begin
      if (accept) begin
         mode <= mode_in;
         word <= mode_in ? code_in : place(data_in);
      end else if (state == CALC) begin
         for (int j = 0; j < PAR_W; j++) begin
            if (int'(k) == j) begin
               if (mode) syn[j] <= cur_par;
               else      word[1 << j] <= cur_par;
            end
         end
      end else if (state == CHECK) begin
         if (mode) ov <= ^word;
         else      word[0] <= ^word[CODE_W-1:1];
      end
   end

endmodule

// File: tb/tb_secded_codec.sv
// Bench for secded_codec: scoreboard of expected results pushed at start, popped at done.
module tb_secded_codec;
   localparam int DATA_W = 11;
   localparam int PAR_W  = 4;
   localparam int CODE_W = DATA_W + PAR_W + 1;
   localparam int LAT    = PAR_W + 2;

   typedef struct {
      logic [CODE_W-1:0] code;
      logic [DATA_W-1:0] data;
      logic [PAR_W-1:0]  syn;
      logic              sec;
      logic              ded;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              mode_in = 1'b0;
   logic [DATA_W-1:0] data_in = '0;
   logic [CODE_W-1:0] code_in = '0;
   logic              busy, done, sec_out, ded_out;
   logic [CODE_W-1:0] code_out;
   logic [DATA_W-1:0] data_out;
   logic [PAR_W-1:0]  syndrome_out;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   secded_codec #(.DATA_W(DATA_W), .PAR_W(PAR_W)) dut (
      .clk(clk), .reset(reset), .start(start), .mode_in(mode_in),
      .data_in(data_in), .code_in(code_in), .busy(busy), .done(done),
      .code_out(code_out), .data_out(data_out), .syndrome_out(syndrome_out),
      .sec_out(sec_out), .ded_out(ded_out)
   );

   always #5 clk = ~clk;

   // Reference model: syndrome as XOR of indices of set bits.
   function automatic logic [CODE_W-1:0] m_place(input logic [DATA_W-1:0] d);
      logic [CODE_W-1:0] w;
      int i;
      w = '0;
      i = 0;
      for (int j = 1; j < CODE_W; j++)
         if ((j & (j - 1)) != 0) begin w[j] = d[i]; i++; end
      return w;
   endfunction

   function automatic logic [DATA_W-1:0] m_extract(input logic [CODE_W-1:0] w);
      logic [DATA_W-1:0] d;
      int i;
      d = '0;
      i = 0;
      for (int j = 1; j < CODE_W; j++)
         if ((j & (j - 1)) != 0) begin d[i] = w[j]; i++; end
      return d;
   endfunction

   function automatic int m_syn(input logic [CODE_W-1:0] w);
      int s;
      s = 0;
      for (int j = 1; j < CODE_W; j++) if (w[j]) s = s ^ j;
      return s;
   endfunction

   function automatic exp_t m_encode(input logic [DATA_W-1:0] d);
      exp_t e;
      logic [CODE_W-1:0] w;
      int s;
      w = m_place(d);
      s = m_syn(w);
      for (int k = 0; k < PAR_W; k++) w[1 << k] = s[k];
      w[0] = ^w[CODE_W-1:1];
      e.code = w; e.data = d; e.syn = '0; e.sec = 1'b0; e.ded = 1'b0;
      return e;
   endfunction

   function automatic exp_t m_decode(input logic [CODE_W-1:0] c);
      exp_t e;
      int s;
      logic ov;
      s = m_syn(c);
      ov = ^c;
      e.code = c; e.sec = 1'b0; e.ded = 1'b0; e.syn = s[PAR_W-1:0];
      if (s == 0 && ov) begin e.code[0] = ~c[0]; e.sec = 1'b1; end
      else if (s != 0 && ov && s < CODE_W) begin e.code[s] = ~c[s]; e.sec = 1'b1; end
      else if (s != 0) e.ded = 1'b1;
      e.data = m_extract(e.code);
      return e;
   endfunction

   // Drive one operation, then wait for done and score it against the queue head.
   task automatic transact(input string name, input logic m, input logic [DATA_W-1:0] d,
                           input logic [CODE_W-1:0] c, input exp_t e);
      int   cyc;
      exp_t x;
      @(negedge clk);
      start = 1'b1; mode_in = m; data_in = d; code_in = c;
      sb.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL %s busy after accept: got %b want 1", name, busy);
      end
      cyc = 0;
      while (done !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
      checks++;
      if (cyc != LAT) begin
         errors++; $display("FAIL %s latency: got %0d edges want %0d", name, cyc, LAT);
      end
      x = sb.pop_front();
      if (done === 1'b1) begin
         checks += 5;
         if (code_out !== x.code) begin
            errors++; $display("FAIL %s code_out: got %h want %h", name, code_out, x.code);
         end
         if (data_out !== x.data) begin
            errors++; $display("FAIL %s data_out: got %h want %h", name, data_out, x.data);
         end
         if (syndrome_out !== x.syn) begin
            errors++; $display("FAIL %s syndrome: got %0d want %0d", name, syndrome_out, x.syn);
         end
         if (sec_out !== x.sec) begin
            errors++; $display("FAIL %s sec: got %b want %b", name, sec_out, x.sec);
         end
         if (ded_out !== x.ded) begin
            errors++; $display("FAIL %s ded: got %b want %b", name, ded_out, x.ded);
         end
      end
   endtask

   function automatic exp_t mk(input logic [CODE_W-1:0] c, input logic [DATA_W-1:0] d,
                               input logic [PAR_W-1:0] s, input logic sc, input logic dd);
      exp_t e;
      e.code = c; e.data = d; e.syn = s; e.sec = sc; e.ded = dd;
      return e;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, sec_out, ded_out} !== 4'b0) begin
         errors++; $display("FAIL reset flags: got %b want 0000", {busy, done, sec_out, ded_out});
      end
      checks++;
      if ({code_out, data_out, syndrome_out} !== '0) begin
         errors++; $display("FAIL reset outputs: got %h/%h/%h want 0", code_out, data_out, syndrome_out);
      end
      @(negedge clk); reset = 1'b0;
   endtask

   task automatic test_encode();
      logic [DATA_W-1:0] d;
      transact("enc_000", 1'b0, 11'h000, '0, mk(16'h0000, 11'h000, 4'd0, 1'b0, 1'b0));
      transact("enc_7ff", 1'b0, 11'h7FF, '0, mk(16'hFFFF, 11'h7FF, 4'd0, 1'b0, 1'b0));
      for (int i = 0; i < 4; i++) begin
         d = DATA_W'($urandom);
         transact("enc_rand", 1'b0, d, CODE_W'($urandom), m_encode(d));
      end
   endtask

   task automatic test_decode();
      exp_t e;
      logic [CODE_W-1:0] c;
      int p1, p2, nflip;
      transact("dec_clean", 1'b1, '0, 16'hFFFF, mk(16'hFFFF, 11'h7FF, 4'd0, 1'b0, 1'b0));
      transact("dec_bit5", 1'b1, '0, 16'hFFDF, mk(16'hFFFF, 11'h7FF, 4'd5, 1'b1, 1'b0));
      transact("dec_p0", 1'b1, '0, 16'hFFFE, mk(16'hFFFF, 11'h7FF, 4'd0, 1'b1, 1'b0));
      transact("dec_double", 1'b1, '0, 16'hFFFC, mk(16'hFFFC, 11'h7FF, 4'd1, 1'b0, 1'b1));
      for (int i = 0; i < 9; i++) begin
         e = m_encode(DATA_W'($urandom));
         c = e.code;
         nflip = i % 3;
         p1 = $urandom_range(0, CODE_W - 1);
         p2 = (p1 + $urandom_range(1, CODE_W - 1)) % CODE_W;
         if (nflip >= 1) c[p1] = ~c[p1];
         if (nflip == 2) c[p2] = ~c[p2];
         transact("dec_rand", 1'b1, DATA_W'($urandom), c, m_decode(c));
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      e = m_encode(11'h2A5);
      transact("b2b_enc", 1'b0, 11'h2A5, '0, e);
      transact("b2b_dec", 1'b1, '0, e.code ^ 16'h0400, m_decode(e.code ^ 16'h0400));
      @(posedge clk); #1;
      checks++;
      if ({done, busy} !== 2'b00) begin
         errors++; $display("FAIL done_pulse_width: got done,busy=%b want 00", {done, busy});
      end
   endtask

   task automatic test_busy_ignore();
      int ndone;
      exp_t e, x;
      e = m_encode(11'h155);
      @(negedge clk);
      start = 1'b1; mode_in = 1'b0; data_in = 11'h155;
      sb.push_back(e);
      @(posedge clk); #1;
      data_in = 11'h6AA; mode_in = 1'b1; code_in = 16'h1234;
      repeat (3) @(posedge clk);
      #1; start = 1'b0;
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            ndone++;
            x = sb.pop_front();
            checks++;
            if (code_out !== x.code) begin
               errors++; $display("FAIL busy_ignore code_out: got %h want %h", code_out, x.code);
            end
         end
      end
      checks++;
      if (ndone != 1) begin
         errors++; $display("FAIL busy_ignore done count: got %0d want 1", ndone);
      end
   endtask

   task automatic test_mid_reset();
      int ndone;
      @(negedge clk);
      start = 1'b1; mode_in = 1'b0; data_in = 11'h3C3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({busy, done, sec_out, ded_out, code_out, data_out, syndrome_out} !== '0) begin
         errors++;
         $display("FAIL mid_reset outputs: got busy=%b done=%b code=%h data=%h syn=%h want 0",
                  busy, done, code_out, data_out, syndrome_out);
      end
      @(negedge clk); reset = 1'b0;
      ndone = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) ndone++;
      end
      checks++;
      if (ndone != 0) begin
         errors++; $display("FAIL mid_reset done count: got %0d want 0", ndone);
      end
   endtask

   initial begin
      test_reset();
      test_encode();
      test_decode();
      test_back_to_back();
      test_busy_ignore();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end
endmodule
